// File: rtl/pio_read_arbiter_if.sv
// Bundle between the PIO read arbiter, its requesters and the input-PIO slave.
// The arbiter takes the slave modport; the requester/PIO side takes master.
interface pio_read_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ-1:0]        req_grant;
  logic [NUM_REQ-1:0]        req_readdatavalid;
  logic [DATA_W-1:0]         req_readdata;
  logic                      busy;
  logic [ADDR_W-1:0]         pio_address;
  logic [DATA_W-1:0]         pio_readdata;

  modport slave (
    input  req_read, req_address, pio_readdata,
    output req_grant, req_readdatavalid, req_readdata, busy, pio_address
  );

  modport master (
    output req_read, req_address, pio_readdata,
    input  req_grant, req_readdatavalid, req_readdata, busy, pio_address
  );
endinterface

// File: rtl/pio_read_arbiter.sv
// Round-robin arbiter sharing one strobe-less input-PIO read port among NUM_REQ
// requesters; one read in flight, data captured READ_LATENCY+1 edges after grant.
module pio_read_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  pio_read_arbiter_if.slave   bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t              state_r, state_next_s;
  logic [PTR_W-1:0]    rr_ptr_r, rr_ptr_next_s, sel_s;
  logic                found_s;
  logic [CNT_W-1:0]    cnt_r, cnt_next_s;
  logic [NUM_REQ-1:0]  grant_r, grant_next_s;
  logic [NUM_REQ-1:0]  valid_r, valid_next_s;
  logic [DATA_W-1:0]   rdata_r, rdata_next_s;
  logic [ADDR_W-1:0]   addr_r, addr_next_s;
  logic                busy_r;
  logic [ADDR_W-1:0]   req_addr_s [NUM_REQ];

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign req_addr_s[i] = bus.req_address[i*ADDR_W +: ADDR_W];
  end

  // Round-robin pick: first active request strictly after the last served one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = {PTR_W{1'b0}};
    found_s = 1'b0;
    sel_s   = rr_ptr_r;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr_r) + k) % NUM_REQ);
      if (!found_s && bus.req_read[idx]) begin
        found_s = 1'b1;
        sel_s   = idx;
      end else begin
        found_s = found_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_next_s  = state_r;
    rr_ptr_next_s = rr_ptr_r;
    cnt_next_s    = cnt_r;
    grant_next_s  = {NUM_REQ{1'b0}};
    valid_next_s  = {NUM_REQ{1'b0}};
    rdata_next_s  = rdata_r;
    addr_next_s   = addr_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          grant_next_s  = onehot(sel_s);
          addr_next_s   = req_addr_s[sel_s];
          rr_ptr_next_s = sel_s;
          cnt_next_s    = CNT_W'(READ_LATENCY);
          state_next_s  = WAIT;
        end else begin
          state_next_s  = IDLE;
        end
      end
      WAIT: begin
        // Requests are not looked at here; they remain pending as levels.
        if (cnt_r == CNT_W'(1)) begin
          state_next_s = CAPTURE;
        end else begin
          cnt_next_s   = cnt_r - CNT_W'(1);
        end
      end
      CAPTURE: begin
        rdata_next_s = bus.pio_readdata;
        valid_next_s = onehot(rr_ptr_r);
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Registered outputs, pointer and latency counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_r <= PTR_W'(NUM_REQ - 1);
      cnt_r    <= {CNT_W{1'b0}};
      grant_r  <= {NUM_REQ{1'b0}};
      valid_r  <= {NUM_REQ{1'b0}};
      rdata_r  <= {DATA_W{1'b0}};
      addr_r   <= {ADDR_W{1'b0}};
      busy_r   <= 1'b0;
    end else begin
      rr_ptr_r <= rr_ptr_next_s;
      cnt_r    <= cnt_next_s;
      grant_r  <= grant_next_s;
      valid_r  <= valid_next_s;
      rdata_r  <= rdata_next_s;
      addr_r   <= addr_next_s;
      busy_r   <= (state_next_s != IDLE);
    end
  end

  assign bus.req_grant         = grant_r;
  assign bus.req_readdatavalid = valid_r;
  assign bus.req_readdata      = rdata_r;
  assign bus.busy              = busy_r;
  assign bus.pio_address       = addr_r;

endmodule
